spi_cfg_regs: RTL and testbench
===============================

Name: spi_cfg_regs

Overview:
- SPI-slave configuration register file for the 1-bit AM SDR core.
- Sits directly upstream of the receiver datapath: takes the raw SCK/MOSI/CSb pads, synchronises them into clk, and drives the tuning/gain register bus the core consumes (NCO phase increment, decimator shift, PWM gain).
- Write-only: no MISO path exists.

Parameters:
- NUM_REGS, 4, number of DATA_W-bit registers; power of two, 2..128.
- DATA_W, 16, register width and SPI data word length.
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- SCK  input  1  raw SPI clock, asynchronous to clk, mode 0.
- MOSI  input  1  raw SPI data, MSB first.
- CSb  input  1  raw active-low chip select.
- cfg_regs  output  NUM_REGS*DATA_W  flat register bus; reg n occupies bits [n*DATA_W +: DATA_W].
- wr_stb  output  1  one-clk pulse, coincident with a register update.
- wr_addr  output  ADDR_W  address of the register just written; valid while wr_stb=1.
- frame_err  output  1  one-clk pulse on a truncated frame.

Behaviour:
- Reset (async, rst=1): all cfg_regs=0, wr_stb=0, wr_addr=0, frame_err=0, state=IDLE, counters=0.
- Reset synchronisers: SCK/MOSI/CSb each pass through 2 flops (s1, s2). SCK and CSb have a third flop s3 for edge detect. Sync flops reset to SCK=0, MOSI=0, CSb=1.
- sck_rise = s2 & ~s3 on SCK. cs_fall / cs_rise are the same construct on CSb.
- MOSI bit is sampled from synced MOSI s2 in the cycle sck_rise=1.
- Timing requirement: SCK high and low each ≥3 clk periods. MOSI stable ≥3 clk around each SCK rise.
- Frame format: 8-bit command byte, then one or more DATA_W-bit words.
  - Command bit7=1 means write.
  - bits[ADDR_W-1:0] give the start address.
  - bits[6:ADDR_W] must be 0.
- FSM:
  - IDLE: wait for cs_fall, then go to CMD with bitcnt=0.
  - CMD: shift 8 bits. On the 8th sck_rise, decode the command.
    - Valid write: go to DATA, latch address.
    - bit7=0 or any nonzero upper address bit: go to DISCARD.
  - DATA: shift DATA_W bits. On the DATA_W-th sck_rise, on that same clk edge:
    - reg[addr] <= {shift[DATA_W-2:0], MOSI}; wr_stb <= 1; wr_addr <= addr.
    - addr increments modulo NUM_REGS (burst auto-increment, wraps NUM_REGS-1 -> 0).
    - bitcnt returns to 0 and the FSM stays in DATA.
  - DISCARD: ignore SCK until cs_rise.
  - Any state: cs_rise returns the FSM to IDLE and clears bitcnt and shift.
- frame_err pulses for 1 clk on cs_rise when:
  - state=CMD with bitcnt≠0, or
  - state=DATA with bitcnt≠0.
  - The partial word is discarded; no register changes.
  - A clean CSb rise in CMD with bitcnt=0 raises no error.
- Latency: the register update is visible on cfg_regs 3 clk edges after the raw SCK rise of the last data bit, +1 clk of sampling uncertainty.
- Register hold: registers hold their values indefinitely between writes. No clearing occurs on CSb.
- cs_fall while not IDLE is impossible in the synced domain. If cs_rise and sck_rise occur in the same cycle, cs_rise wins and the bit is dropped.
- Reset mid-frame: rst aborts immediately. After rst deasserts, FSM stays IDLE until a fresh cs_fall. A frame already in progress (CSb still low) is ignored until CSb goes high then low again.

Test Plan:
- Write to reg 1: CSb low, cmd 0x81, data 0xBEEF, CSb high -> cfg_regs[31:16]=0xBEEF, others 0, single wr_stb with wr_addr=1, frame_err=0.
- Burst with wrap: cmd 0x83, words 0x1111, 0x2222, 0x3333 -> reg3=0x1111, reg0=0x2222, reg1=0x3333; three wr_stb pulses with wr_addr 3, 0, 1.
- Truncated frame: write 0xABCD to reg2, then cmd 0x82 with only 9 data bits, then CSb high -> reg2 stays 0xABCD, no wr_stb, one frame_err pulse.
- Rejected commands: cmd 0x02 (read) or 0x84 (upper address bits set) followed by 16 bits -> no register change, no wr_stb, no frame_err.
- Reset mid-frame: assert rst after 12 data bits of a write to reg0 -> all regs 0 immediately. Remaining SCK edges before CSb high have no effect. The next complete frame writes normally.
- Minimum SCK timing: SCK high = low = 3 clk, random phase vs clk -> all words received bit-exact over 100 random writes.

Source files
------------

// File: rtl/spi_cfg_regs.sv
// -----------------------------------------------------------------------------
// spi_cfg_regs
//
// Write-only SPI-slave (mode 0, MSB first) configuration register file for the
// 1-bit AM SDR core. The raw SCK/MOSI/CSb pads are synchronised into clk. The
// SPI frames then update a bank of DATA_W-bit tuning/gain registers. The
// receiver datapath reads those registers as one flat bus.
//
// Frame: 8-bit command {wr, 0.., addr[ADDR_W-1:0]}, then one or more DATA_W-bit
// words. The register address auto-increments and wraps after every word.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   SCK        raw SPI clock (asynchronous to clk)
//   MOSI       raw SPI data, MSB first
//   CSb        raw active-low chip select
//   cfg_regs   flat register bus, reg n at [n*DATA_W +: DATA_W]
//   wr_stb     one-clk pulse, coincident with a register update
//   wr_addr    address of the register just written (valid with wr_stb)
//   frame_err  one-clk pulse when CSb rises in the middle of a command/word
// -----------------------------------------------------------------------------
module spi_cfg_regs #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16,
    // Derived from NUM_REGS; leave at its default.
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCK,
    input  logic                       MOSI,
    input  logic                       CSb,
    output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    // The shifter must also hold the 8-bit command byte.
    localparam int SH_W  = (DATA_W > 8) ? DATA_W : 8;
    localparam int CNT_W = $clog2(SH_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pad synchronisers. The third SCK/CSb stage provides edge detection.
    // ------------------------------------------------------------------
    logic sck_s1, sck_s2, sck_s3;
    logic mosi_s1, mosi_s2;
    logic cs_s1, cs_s2, cs_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a real shift chain.
            sck_s1  <= SCK;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            cs_s1   <= CSb;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
        end
    end

    logic sck_rise, cs_fall, cs_rise;
    assign sck_rise = sck_s2 & ~sck_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;
    assign cs_rise  = cs_s2 & ~cs_s3;

    // ------------------------------------------------------------------
    // Frame arming. The CSb synchroniser resets to "deselected". If the
    // pad is already low when rst is released, the refill looks like a
    // falling edge. A start of frame is therefore accepted only after a
    // real high level has been seen on CSb. A frame that rst cut short
    // is then ignored until CSb is cycled high and low again.
    // ------------------------------------------------------------------
    logic [1:0] prime_cnt;
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= 2'd0;
            armed     <= 1'b0;
        end else if (prime_cnt != 2'd2) begin
            // Wait until cs_s2 holds a genuine pad sample.
            prime_cnt <= prime_cnt + 2'd1;
        end else if (cs_s2) begin
            armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command decode, taken from the byte completed by the current bit.
    // ------------------------------------------------------------------
    logic [7:0]        cmd_byte;
    logic [6:0]        cmd_upper;
    logic              cmd_ok;
    logic [ADDR_W-1:0] cmd_addr;

    logic [SH_W-1:0]   shift;

    assign cmd_byte  = {shift[6:0], mosi_s2};
    // The bits between the address field and the write flag must be zero.
    assign cmd_upper = cmd_byte[6:0] >> ADDR_W;
    assign cmd_ok    = cmd_byte[7] && (cmd_upper == 7'd0);
    assign cmd_addr  = cmd_byte[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // Frame FSM and register bank
    // ------------------------------------------------------------------
    state_t              state;
    logic [CNT_W-1:0]    bitcnt;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shift     <= '0;
            addr      <= '0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            // NOTE: the bank is a small set of flops that drives the core
            // directly, so it is reset to a known state; this would be wrong
            // for a RAM macro, which has no reset.
            for (int n = 0; n < NUM_REGS; n++) begin
                regs[n] <= '0;
            end
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;

            if (cs_rise) begin
                // Deselect always ends the frame. If it arrives in the same
                // cycle as an SCK rise, that bit is dropped. A partial
                // command or word is flagged and thrown away.
                if ((state == CMD || state == DATA) && bitcnt != '0) begin
                    frame_err <= 1'b1;
                end
                state  <= IDLE;
                bitcnt <= '0;
                shift  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall && armed) begin
                            state  <= CMD;
                            bitcnt <= '0;
                            shift  <= '0;
                        end
                    end

                    CMD: begin
                        if (sck_rise) begin
                            shift <= {shift[SH_W-2:0], mosi_s2};
                            if (bitcnt == CNT_W'(7)) begin
                                bitcnt <= '0;
                                if (cmd_ok) begin
                                    state <= DATA;
                                    addr  <= cmd_addr;
                                end else begin
                                    state <= DISCARD;
                                end
                            end else begin
                                bitcnt <= bitcnt + CNT_W'(1);
                            end
                        end
                    end

                    DATA: begin
                        if (sck_rise) begin
                            shift <= {shift[SH_W-2:0], mosi_s2};
                            if (bitcnt == CNT_W'(DATA_W - 1)) begin
                                regs[addr] <= {shift[DATA_W-2:0], mosi_s2};
                                wr_stb     <= 1'b1;
                                wr_addr    <= addr;
                                // Burst auto-increment; wraps naturally at NUM_REGS.
                                addr       <= addr + ADDR_W'(1);
                                bitcnt     <= '0;
                            end else begin
                                bitcnt <= bitcnt + CNT_W'(1);
                            end
                        end
                    end

                    DISCARD: begin
                        // Rejected command: wait for deselect.
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_cfg_regs.sv
// -----------------------------------------------------------------------------
// tb_spi_cfg_regs
//
// Self-checking bench for spi_cfg_regs. SPI frames are driven asynchronously
// to clk. Every expected register write is pushed to a scoreboard queue when
// its frame is driven. A monitor pops the queue on each wr_stb and compares
// the address and register contents. Each test ends with a comparison of the
// whole register bank against a reference model, the pending queue and the
// frame_err count.
// -----------------------------------------------------------------------------
module tb_spi_cfg_regs;

    localparam int  NUM_REGS = 4;
    localparam int  DATA_W   = 16;
    localparam int  ADDR_W   = 2;
    localparam time TCLK     = 10;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       sck;
    logic                       mosi;
    logic                       csb;
    logic [NUM_REGS*DATA_W-1:0] cfg_regs;
    logic                       wr_stb;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       frame_err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] model [NUM_REGS];

    int total    = 0;
    int bad      = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int half     = 4;   // SCK half period in clk cycles

    spi_cfg_regs #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SCK      (sck),
        .MOSI     (mosi),
        .CSb      (csb),
        .cfg_regs (cfg_regs),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .frame_err(frame_err)
    );

    always #(TCLK/2) clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard monitor. It samples 1 ns after each active edge.
    // ------------------------------------------------------------------
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (frame_err === 1'b1) err_seen++;
            if (wr_stb === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_wr_stb: wr_addr=%0d, none expected", wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr ||
                        cfg_regs[e.addr*DATA_W +: DATA_W] !== e.data) begin
                        bad++;
                        $display("FAIL wr_stb_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 wr_addr, cfg_regs[e.addr*DATA_W +: DATA_W], e.addr, e.data);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // SPI driver primitives
    // ------------------------------------------------------------------
    task automatic spi_start();
        csb = 1'b0;
        #(4*TCLK + $urandom_range(0, 9));   // random phase against clk
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            // MOSI changes at the start of the low phase, so it is stable
            // for a full half period on either side of the rising edge.
            mosi = val[i];
            #(half*TCLK);
            sck = 1'b1;
            #(half*TCLK);
            sck = 1'b0;
        end
    endtask

    task automatic spi_end();
        #(half*TCLK);
        csb = 1'b1;
        #(8*TCLK);
    endtask

    // One write frame of nw words (1..3) starting at addr. The model and the
    // scoreboard are updated before the frame is driven.
    task automatic write_burst(input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] w0,
                               input logic [DATA_W-1:0] w1,
                               input logic [DATA_W-1:0] w2,
                               input int nw);
        logic [DATA_W-1:0] w [3];
        logic [ADDR_W-1:0] a;
        w[0] = w0; w[1] = w1; w[2] = w2;
        a = addr;
        for (int k = 0; k < nw; k++) begin
            exp_q.push_back('{addr: a, data: w[k]});
            model[a] = w[k];
            a = a + ADDR_W'(1);
        end
        spi_start();
        spi_bits({24'd0, 1'b1, 5'd0, addr}, 8);
        for (int k = 0; k < nw; k++) spi_bits({16'd0, w[k]}, DATA_W);
        spi_end();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        csb  = 1'b1;
        for (int n = 0; n < NUM_REGS; n++) model[n] = '0;
        #(3*TCLK + 2);
        total++;
        if (cfg_regs !== '0 || wr_stb !== 1'b0 || wr_addr !== '0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: regs=%h stb=%b addr=%0d err=%b, expected all zero",
                     cfg_regs, wr_stb, wr_addr, frame_err);
        end
        @(negedge clk);
        rst = 1'b0;
        #(6*TCLK);
    endtask

    task automatic test_single_write();
        write_burst(2'd1, 16'hBEEF, 16'h0, 16'h0, 1);
        total++;
        if (cfg_regs !== 64'h0000_0000_BEEF_0000) begin
            bad++;
            $display("FAIL single_write: regs=%h, expected %h", cfg_regs, 64'h0000_0000_BEEF_0000);
        end
        for (int n = 0; n < NUM_REGS; n++) begin
            total++;
            if (cfg_regs[n*DATA_W +: DATA_W] !== model[n]) begin
                bad++;
                $display("FAIL single_reg%0d: got %h expected %h", n, cfg_regs[n*DATA_W +: DATA_W], model[n]);
            end
        end
        total++;
        if (exp_q.size() != 0 || err_seen != err_exp) begin
            bad++;
            $display("FAIL single_status: pending=%0d err=%0d, expected pending=0 err=%0d",
                     exp_q.size(), err_seen, err_exp);
        end
    endtask

    task automatic test_burst_wrap();
        write_burst(2'd3, 16'h1111, 16'h2222, 16'h3333, 3);
        total++;
        if (cfg_regs !== 64'h1111_0000_3333_2222) begin
            bad++;
            $display("FAIL burst_wrap: regs=%h, expected %h", cfg_regs, 64'h1111_0000_3333_2222);
        end
        total++;
        if (exp_q.size() != 0 || err_seen != err_exp) begin
            bad++;
            $display("FAIL burst_status: pending=%0d err=%0d, expected pending=0 err=%0d",
                     exp_q.size(), err_seen, err_exp);
        end
    endtask

    task automatic test_truncated();
        write_burst(2'd2, 16'hABCD, 16'h0, 16'h0, 1);
        // Write command to reg2 with only 9 of 16 data bits.
        spi_start();
        spi_bits(32'h82, 8);
        spi_bits(32'h1FF, 9);
        spi_end();
        err_exp++;
        for (int n = 0; n < NUM_REGS; n++) begin
            total++;
            if (cfg_regs[n*DATA_W +: DATA_W] !== model[n]) begin
                bad++;
                $display("FAIL trunc_reg%0d: got %h expected %h", n, cfg_regs[n*DATA_W +: DATA_W], model[n]);
            end
        end
        total++;
        if (exp_q.size() != 0 || err_seen != err_exp) begin
            bad++;
            $display("FAIL trunc_status: pending=%0d err=%0d, expected pending=0 err=%0d",
                     exp_q.size(), err_seen, err_exp);
        end
    endtask

    task automatic test_rejected();
        logic [7:0] cmds [2];
        cmds[0] = 8'h02;   // read: not supported
        cmds[1] = 8'h84;   // address bit above ADDR_W set
        for (int c = 0; c < 2; c++) begin
            spi_start();
            spi_bits({24'd0, cmds[c]}, 8);
            spi_bits(32'h5A5A, 16);
            spi_end();
            for (int n = 0; n < NUM_REGS; n++) begin
                total++;
                if (cfg_regs[n*DATA_W +: DATA_W] !== model[n]) begin
                    bad++;
                    $display("FAIL reject_%h_reg%0d: got %h expected %h",
                             cmds[c], n, cfg_regs[n*DATA_W +: DATA_W], model[n]);
                end
            end
            total++;
            if (exp_q.size() != 0 || err_seen != err_exp) begin
                bad++;
                $display("FAIL reject_%h_status: pending=%0d err=%0d, expected pending=0 err=%0d",
                         cmds[c], exp_q.size(), err_seen, err_exp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        spi_start();
        spi_bits(32'h80, 8);
        spi_bits(32'hC3A, 12);   // first 12 bits of 0xC3A5
        rst = 1'b1;
        for (int n = 0; n < NUM_REGS; n++) model[n] = '0;
        #1;
        total++;
        if (cfg_regs !== '0) begin
            bad++;
            $display("FAIL midrst_clear: regs=%h, expected 0", cfg_regs);
        end
        #(3*TCLK);
        @(negedge clk);
        rst = 1'b0;
        spi_bits(32'h5, 4);      // rest of the aborted frame
        spi_end();
        total++;
        if (cfg_regs !== '0 || exp_q.size() != 0 || err_seen != err_exp) begin
            bad++;
            $display("FAIL midrst_tail: regs=%h pending=%0d err=%0d, expected 0/0/%0d",
                     cfg_regs, exp_q.size(), err_seen, err_exp);
        end
        write_burst(2'd0, 16'h600D, 16'h0, 16'h0, 1);
        total++;
        if (cfg_regs !== 64'h0000_0000_0000_600D || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_next: regs=%h pending=%0d, expected %h/0",
                     cfg_regs, exp_q.size(), 64'h600D);
        end
    endtask

    task automatic test_min_timing_random();
        half = 3;
        for (int i = 0; i < 100; i++) begin
            write_burst(ADDR_W'($urandom_range(0, NUM_REGS - 1)),
                        DATA_W'($urandom), 16'h0, 16'h0, 1);
        end
        for (int n = 0; n < NUM_REGS; n++) begin
            total++;
            if (cfg_regs[n*DATA_W +: DATA_W] !== model[n]) begin
                bad++;
                $display("FAIL random_reg%0d: got %h expected %h", n, cfg_regs[n*DATA_W +: DATA_W], model[n]);
            end
        end
        total++;
        if (exp_q.size() != 0 || err_seen != err_exp) begin
            bad++;
            $display("FAIL random_status: pending=%0d err=%0d, expected pending=0 err=%0d",
                     exp_q.size(), err_seen, err_exp);
        end
        half = 4;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_truncated();
        test_rejected();
        test_reset_mid_frame();
        test_min_timing_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
